// File: rtl/jtag_pkg.sv
// Shared debug-module definitions: DMI register addresses, sberror codes,
// sbaccess size encodings and the system-bus-access FSM states.
package jtag_pkg;

  localparam logic [6:0] SBCS       = 7'h38;
  localparam logic [6:0] SBADDRESS0 = 7'h39;
  localparam logic [6:0] SBDATA0    = 7'h3C;

  localparam logic [2:0] SBERR_NONE    = 3'd0;
  localparam logic [2:0] SBERR_BADADDR = 3'd2;
  localparam logic [2:0] SBERR_ALIGN   = 3'd3;
  localparam logic [2:0] SBERR_SIZE    = 3'd4;

  localparam logic [2:0] SBACCESS8  = 3'd0;
  localparam logic [2:0] SBACCESS16 = 3'd1;
  localparam logic [2:0] SBACCESS32 = 3'd2;

  typedef enum logic [1:0] {
    SBA_IDLE,
    SBA_ISSUE,
    SBA_WAIT
  } sba_state_e;

endpackage

// File: rtl/jtag_sba_regs.sv
// DMI-side sbcs/sbaddress0/sbdata0 registers; decodes DMI accesses into
// single bus accesses handed to jtag_sba over a start/done interface.
module jtag_sba_regs
  import jtag_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmi_req_i,
  input  logic        dmi_we_i,
  input  logic [6:0]  dmi_addr_i,
  input  logic [31:0] dmi_wdata_i,
  output logic        dmi_rvalid_o,
  output logic [31:0] dmi_rdata_o,
  output logic        sba_start_o,
  output logic        sba_we_o,
  output logic [2:0]  sba_size_o,
  output logic [31:0] sba_addr_o,
  output logic [31:0] sba_wdata_o,
  input  logic        sba_busy_i,
  input  logic        sba_done_i,
  input  logic [31:0] sba_rdata_i,
  input  logic        sba_err_i
);

  sba_state_e  state_q, state_d;
  logic        readonaddr_q, readonaddr_d;
  logic [2:0]  access_q, access_d;
  logic        autoinc_q, autoinc_d;
  logic        readondata_q, readondata_d;
  logic [2:0]  sberror_q, sberror_d;
  logic        sbbusyerror_q, sbbusyerror_d;
  logic [31:0] sbaddr_q, sbaddr_d;
  logic [31:0] sbdata_q, sbdata_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        sbbusy;
  logic        errPending;
  logic        trigger;
  logic        trigRead;
  logic [31:0] trigAddr;
  logic [2:0]  checkErr;
  logic        start;
  logic [31:0] sbcsValue;

  // Size check first, then natural alignment for the requested width.
  function automatic logic [2:0] checkAccess(input logic [2:0] access,
                                             input logic [31:0] addr);
    logic [2:0] err;
    err = SBERR_NONE;
    if (access > SBACCESS32) begin
      err = SBERR_SIZE;
    end else if (access == SBACCESS16 && addr[0] != 1'b0) begin
      err = SBERR_ALIGN;
    end else if (access == SBACCESS32 && addr[1:0] != 2'b00) begin
      err = SBERR_ALIGN;
    end
    return err;
  endfunction

  function automatic logic [31:0] zeroExtend(input logic [2:0] size,
                                             input logic [31:0] data);
    logic [31:0] res;
    case (size)
      SBACCESS8:  res = {24'd0, data[7:0]};
      SBACCESS16: res = {16'd0, data[15:0]};
      default:    res = data;
    endcase
    return res;
  endfunction

  assign sbbusy     = (state_q != SBA_IDLE);
  assign errPending = (sberror_q != SBERR_NONE) || sbbusyerror_q;

  assign sbcsValue = {3'd1, 6'd0, sbbusyerror_q, sbbusy, readonaddr_q,
                      access_q, autoinc_q, readondata_q, sberror_q,
                      7'd32, 2'b00, 3'b111};

  always_comb begin
    state_d       = state_q;
    readonaddr_d  = readonaddr_q;
    access_d      = access_q;
    autoinc_d     = autoinc_q;
    readondata_d  = readondata_q;
    sberror_d     = sberror_q;
    sbbusyerror_d = sbbusyerror_q;
    sbaddr_d      = sbaddr_q;
    sbdata_d      = sbdata_q;
    we_d          = we_q;
    size_d        = size_q;
    rvalid_d      = 1'b0;
    rdata_d       = rdata_q;
    trigger       = 1'b0;
    trigRead      = 1'b0;
    trigAddr      = sbaddr_q;
    checkErr      = SBERR_NONE;
    start         = 1'b0;

    if (dmi_req_i && !dmi_we_i) begin
      rvalid_d = 1'b1;
      case (dmi_addr_i)
        SBCS:       rdata_d = sbcsValue;
        SBADDRESS0: rdata_d = sbaddr_q;
        SBDATA0:    rdata_d = sbdata_q;
        default:    rdata_d = 32'd0;
      endcase
      // Old sbdata0 is returned; the read it triggers refills it later.
      if (dmi_addr_i == SBDATA0) begin
        if (sbbusy) begin
          sbbusyerror_d = 1'b1;
        end else if (readondata_q) begin
          trigger  = 1'b1;
          trigRead = 1'b1;
        end
      end
    end

    if (dmi_req_i && dmi_we_i) begin
      case (dmi_addr_i)
        SBCS: begin
          readonaddr_d  = dmi_wdata_i[20];
          access_d      = dmi_wdata_i[19:17];
          autoinc_d     = dmi_wdata_i[16];
          readondata_d  = dmi_wdata_i[15];
          sbbusyerror_d = sbbusyerror_q & ~dmi_wdata_i[22];
          sberror_d     = sberror_q & ~dmi_wdata_i[14:12];
        end
        SBADDRESS0: begin
          if (sbbusy) begin
            sbbusyerror_d = 1'b1;
          end else begin
            sbaddr_d = dmi_wdata_i;
            trigAddr = dmi_wdata_i;
            if (readonaddr_q) begin
              trigger  = 1'b1;
              trigRead = 1'b1;
            end
          end
        end
        SBDATA0: begin
          if (sbbusy) begin
            sbbusyerror_d = 1'b1;
          end else begin
            sbdata_d = dmi_wdata_i;
            trigger  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Done-side error assignment comes last so it wins over a W1C in the same cycle.
    case (state_q)
      SBA_IDLE: begin
        if (trigger && !errPending) begin
          checkErr = checkAccess(access_q, trigAddr);
          if (checkErr != SBERR_NONE) begin
            sberror_d = checkErr;
          end else begin
            state_d = SBA_ISSUE;
            we_d    = !trigRead;
            size_d  = access_q;
          end
        end
      end
      SBA_ISSUE: begin
        if (!sba_busy_i) begin
          start   = 1'b1;
          state_d = SBA_WAIT;
        end
      end
      SBA_WAIT: begin
        if (sba_done_i) begin
          state_d = SBA_IDLE;
          if (sba_err_i) begin
            sberror_d = SBERR_BADADDR;
          end else begin
            if (!we_q) begin
              sbdata_d = zeroExtend(size_q, sba_rdata_i);
            end
            if (autoinc_q) begin
              sbaddr_d = sbaddr_q + (32'd1 << size_q);
            end
          end
        end
      end
      default: state_d = SBA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= SBA_IDLE;
      readonaddr_q  <= 1'b0;
      access_q      <= SBACCESS32;
      autoinc_q     <= 1'b0;
      readondata_q  <= 1'b0;
      sberror_q     <= SBERR_NONE;
      sbbusyerror_q <= 1'b0;
      sbaddr_q      <= 32'd0;
      sbdata_q      <= 32'd0;
      we_q          <= 1'b0;
      size_q        <= SBACCESS32;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      readonaddr_q  <= readonaddr_d;
      access_q      <= access_d;
      autoinc_q     <= autoinc_d;
      readondata_q  <= readondata_d;
      sberror_q     <= sberror_d;
      sbbusyerror_q <= sbbusyerror_d;
      sbaddr_q      <= sbaddr_d;
      sbdata_q      <= sbdata_d;
      we_q          <= we_d;
      size_q        <= size_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign dmi_rvalid_o = rvalid_q;
  assign dmi_rdata_o  = rdata_q;
  assign sba_start_o  = start;
  assign sba_we_o     = we_q;
  assign sba_size_o   = size_q;
  assign sba_addr_o   = sbaddr_q;
  assign sba_wdata_o  = sbdata_q;

endmodule

// File: doc/jtag_sba_regs.md
Name: jtag_sba_regs

Overview:
- DMI-side front end of system bus access in the debug module, directly upstream of jtag_sba.
- Implements the debug-spec registers sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3C): DMI decode, read/write triggers, autoincrement and error tracking.
- Hands one access at a time to jtag_sba over a start/done command interface.

Parameters:
- none; bus address and data are fixed at 32 bits.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- dmi_req_i  in  1  DMI access strobe, one cycle per access
- dmi_we_i  in  1  1=write, 0=read
- dmi_addr_i  in  7  DMI register address
- dmi_wdata_i  in  32  DMI write data
- dmi_rvalid_o  out  1  read data valid, one cycle after a read strobe
- dmi_rdata_o  out  32  registered read data
- sba_start_o  out  1  one-cycle pulse starting a bus access
- sba_we_o  out  1  access direction, stable from start to done
- sba_size_o  out  3  sbaccess encoding: 0=8b, 1=16b, 2=32b
- sba_addr_o  out  32  access address (current sbaddress0)
- sba_wdata_o  out  32  write data (current sbdata0)
- sba_busy_i  in  1  jtag_sba busy; start is only issued when low
- sba_done_i  in  1  one-cycle completion pulse
- sba_rdata_i  in  32  read data, right-justified, valid with done
- sba_err_i  in  1  bus error, valid with done

Behaviour:
- Reset values:
  - sbcs: readonaddr=0, access=2, autoincrement=0, readondata=0, sberror=0, sbbusyerror=0.
  - sbaddress0=0, sbdata0=0, state=IDLE.
  - All outputs 0, except sba_size_o=2.
- Reset mid-access discards the access; a late sba_done_i in IDLE is ignored.
- sbcs read value:
  - version[31:29]=1, sbbusyerror[22], sbbusy[21], readonaddr[20], access[19:17], autoincrement[16], readondata[15], sberror[14:12].
  - asize[11:5]=32, access32/16/8 [2:0]=3'b111; all other bits 0.
- sbcs write:
  - Updates readonaddr, access, autoincrement and readondata.
  - sbbusyerror and sberror are write-1-to-clear.
- DMI reads: dmi_rdata_o and dmi_rvalid_o are registered at T+1. Unmapped addresses read 0 and ignore writes.
- sbbusy = (state != IDLE), evaluated on registered state.
- Triggers, all in IDLE with no error pending:
  - Write sbaddress0 with readonaddr=1 → read.
  - Write sbdata0 → write.
  - Read sbdata0 with readondata=1 → read; the old data is returned first.
- Write sbaddress0 or sbdata0 while sbbusy: sets sbbusyerror, the written register is NOT updated, and no trigger fires.
- Read sbdata0 while sbbusy: sets sbbusyerror and returns the current value.
- Pending error (sberror!=0 or sbbusyerror=1): registers still update, but no access is started.
- Pre-start checks, in order:
  - access>2 → sberror=4.
  - Address not aligned to 1<<access → sberror=3.
  - Either failure: no start issued.
- FSM:
  - IDLE: trigger and checks pass → ISSUE.
  - ISSUE: once sba_busy_i=0, pulse sba_start_o for one cycle → WAIT.
  - WAIT: on sba_done_i → IDLE.
- Completion (on done):
  - sba_err_i=1 → sberror=2; no data update, no increment.
  - Otherwise, a read loads sbdata0 = sba_rdata_i zero-extended to access size.
  - Otherwise, if autoincrement=1, sbaddress0 += 1<<access, mod 2^32 (wraps 0xFFFFFFFC→0 for 32b).
- Latency: trigger cycle T → ISSUE at T+1 → sba_start_o at T+1 if not busy.
- Simultaneous events:
  - Error set from done beats a W1C clear in the same cycle.
  - A DMI access in the done cycle still sees sbbusy=1.

Decomposition:
- Shared package jtag_pkg holds:
  - DMI address constants SBCS/SBADDRESS0/SBDATA0.
  - sberror codes (0 none, 2 bad addr, 3 align, 4 size).
  - sbaccess encodings.
  - FSM state enum.
- Single module; no sub-module is natural. The size/alignment check is a local function.

Test Plan:
- Write sbcs access=2, autoinc=1; write sbaddress0=0x1000; write sbdata0=0xDEADBEEF → one start with we=1, addr 0x1000, wdata 0xDEADBEEF; after done, sbaddress0 reads 0x1004.
- readonaddr=1, access=0; write sbaddress0=0x2003; done with rdata 0x000000A5 → sbdata0=0xA5, sberror=0.
- readondata=1, autoinc=1, access=2, addr 0x3000 → each sbdata0 read returns the prior value and starts the next read; the address steps 0x3004, 0x3008.
- Write sbdata0 while in WAIT → sbbusyerror=1, no second start; a further write is blocked until sbcs is written with bit22=1.
- access=1, addr 0x4001 → sberror=3, no start; access=5 → sberror=4. Done with err=1 → sberror=2, address not incremented; write 3'b111 to [14:12] clears it.
- Autoincrement from 0xFFFFFFFC, 32b access → address wraps to 0; assert rst_n=0 during WAIT → all fields return to reset values and the next done is ignored.
